// File: rtl/seg_pkg.sv
// Shared op encodings and active-low seven-segment patterns for the display scanner.
package seg_pkg;

    typedef enum logic [2:0] {
        OP_CYCLES   = 3'd0,
        OP_JUMPS    = 3'd1,
        OP_BRANCHES = 3'd2,
        OP_TAKEN    = 3'd3,
        OP_PC       = 3'd4,
        OP_RAM      = 3'd5,
        OP_SYSCALL  = 3'd6,
        OP_BLANK    = 3'd7
    } disp_op_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index n holds the {dp,g,f,e,d,c,b,a} pattern for hex digit n, dp off.
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg_display_scan_if.sv
// Switch controls, CPU statistics, RAM debug port and display pins of the display scanner.
// slave = the scanner; master = the surrounding board logic that feeds it.
interface seg_display_scan_if #(
    parameter int ADDR_BITS = 12
);
    logic [2:0]           display_op;
    logic [ADDR_BITS-3:0] ram_display_addr;
    logic [31:0]          syscall_out;
    logic [31:0]          pc;
    logic [31:0]          cycle_cnt;
    logic [31:0]          jump_cnt;
    logic [31:0]          branch_cnt;
    logic [31:0]          taken_cnt;
    logic [ADDR_BITS-3:0] ram_rd_addr;
    logic [31:0]          ram_rd_data;
    logic [7:0]           an;
    logic [7:0]           seg;

    modport master (
        output display_op, ram_display_addr, syscall_out, pc,
               cycle_cnt, jump_cnt, branch_cnt, taken_cnt, ram_rd_data,
        input  ram_rd_addr, an, seg
    );

    modport slave (
        input  display_op, ram_display_addr, syscall_out, pc,
               cycle_cnt, jump_cnt, branch_cnt, taken_cnt, ram_rd_data,
        output ram_rd_addr, an, seg
    );
endinterface

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational; no backpressure.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] pattern
);

    assign pattern = SEG_HEX[nibble];

endmodule

// File: rtl/seg_display_scan.sv
// Scans a per-frame snapshot of the selected 32-bit value onto an 8-digit multiplexed display.
// Latency: an/seg registered 1 clk after the scan state; free-running, no backpressure.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int ADDR_BITS  = 12,
    parameter int SCAN_DIV   = 100_000,
    parameter int LEAD_BLANK = 1
) (
    input  logic              clk,
    input  logic              rst,
    seg_display_scan_if.slave bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]     scan_cnt;
    logic [2:0]           digit_idx;
    logic [31:0]          snapshot;
    disp_op_e             op_q;
    logic                 snap_vld;
    logic [ADDR_BITS-3:0] rd_addr_q;

    logic                 digit_done;
    logic                 frame_end;
    logic [31:0]          sel_value;
    logic [3:0]           nibble;
    logic [7:0]           hex_pat;
    logic                 upper_zero;
    logic [7:0]           an_next;
    logic [7:0]           seg_next;

    assign digit_done = (scan_cnt == CNT_LAST);
    assign frame_end  = digit_done && (digit_idx == 3'd7);

    always_comb begin
        sel_value = 32'd0;
        unique case (disp_op_e'(bus.display_op))
            OP_CYCLES:   sel_value = bus.cycle_cnt;
            OP_JUMPS:    sel_value = bus.jump_cnt;
            OP_BRANCHES: sel_value = bus.branch_cnt;
            OP_TAKEN:    sel_value = bus.taken_cnt;
            OP_PC:       sel_value = bus.pc;
            OP_RAM:      sel_value = bus.ram_rd_data;
            OP_SYSCALL:  sel_value = bus.syscall_out;
            OP_BLANK:    sel_value = 32'd0;
        endcase
    end

    assign nibble     = snapshot[{digit_idx, 2'b00} +: 4];
    assign upper_zero = ((snapshot >> {digit_idx, 2'b00}) == 32'd0);
    assign an_next    = ~(8'b1 << digit_idx);

    seg7_decode u_dec (
        .nibble  (nibble),
        .pattern (hex_pat)
    );

    // The op blank only applies once a real frame has been captured, so the
    // frame right after reset shows the zero snapshot as a single "0".
    always_comb begin
        seg_next = hex_pat;
        if (snap_vld && (op_q == OP_BLANK)) begin
            seg_next = SEG_BLANK;
        end else if ((LEAD_BLANK != 0) && (digit_idx != 3'd0) && upper_zero) begin
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
            snapshot  <= 32'd0;
            op_q      <= OP_BLANK;
            snap_vld  <= 1'b0;
            bus.an    <= 8'hFF;
            bus.seg   <= SEG_BLANK;
        end else begin
            rd_addr_q <= bus.ram_display_addr;
            if (digit_done) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt  <= scan_cnt + CNT_W'(1);
            end
            if (frame_end) begin
                snapshot <= sel_value;
                op_q     <= disp_op_e'(bus.display_op);
                snap_vld <= 1'b1;
            end
            bus.an  <= an_next;
            bus.seg <= seg_next;
        end
    end

    assign bus.ram_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Randomized bench for seg_display_scan against an edge-count based display model.
module tb_seg_display_scan;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 8 * SCAN_DIV;

    logic clk;
    logic rst;

    seg_display_scan_if #(.ADDR_BITS(12)) bus ();

    seg_display_scan #(
        .ADDR_BITS  (12),
        .SCAN_DIV   (SCAN_DIV),
        .LEAD_BLANK (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always @(posedge clk) bus.ram_rd_data <= mem[bus.ram_rd_addr];

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int errors = 0;
    int checks = 0;

    // Model: frame/digit follow from the number of edges since reset release.
    int          pos = 0;
    int          cur_digit = 0;
    logic [31:0] m_snap = 0;
    logic [2:0]  m_op = 3'd7;
    bit          m_vld = 0;
    logic [9:0]  addr_d1 = 0;
    logic [9:0]  addr_d2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (pos=%0d)", tag, obs, exp, pos);
        end
    endtask

    function automatic logic [7:0] exp_seg(input logic [31:0] v, input logic [2:0] op,
                                           input bit vld, input int d);
        logic [31:0] up;
        up = v >> (4 * d);
        if (vld && op == 3'd7) return 8'hFF;
        if (d > 0 && up == 32'd0) return 8'hFF;
        return hex_tab[up[3:0]];
    endfunction

    task automatic tick();
        logic [7:0]  e_an;
        logic [7:0]  e_seg;
        logic [9:0]  e_addr;
        logic [31:0] v;
        @(posedge clk);
        if (rst) begin
            pos = 0; cur_digit = 0;
            m_snap = 0; m_op = 3'd7; m_vld = 0;
            e_an = 8'hFF; e_seg = 8'hFF; e_addr = 10'd0;
        end else begin
            pos++;
            cur_digit = ((pos - 1) / SCAN_DIV) % 8;
            e_an   = ~(8'h01 << cur_digit);
            e_seg  = exp_seg(m_snap, m_op, m_vld, cur_digit);
            e_addr = bus.ram_display_addr;
            if (pos % FRAME == 0) begin
                case (bus.display_op)
                    3'd0: v = bus.cycle_cnt;
                    3'd1: v = bus.jump_cnt;
                    3'd2: v = bus.branch_cnt;
                    3'd3: v = bus.taken_cnt;
                    3'd4: v = bus.pc;
                    3'd5: v = mem[addr_d2];
                    3'd6: v = bus.syscall_out;
                    default: v = 32'd0;
                endcase
                m_snap = v; m_op = bus.display_op; m_vld = 1;
            end
        end
        addr_d2 = addr_d1;
        addr_d1 = e_addr;
        #1;
        chk("an", 32'(bus.an), 32'(e_an));
        chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("ram_rd_addr", 32'(bus.ram_rd_addr), 32'(e_addr));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align_frame();
        int n;
        n = 0;
        while (pos % FRAME != 0 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk("align", 32'(pos % FRAME), 32'd0);
    endtask

    task automatic wait_digit(input int d);
        int n;
        n = 0;
        while (cur_digit != d && n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk("wait_digit", 32'(cur_digit), 32'(d));
    endtask

    // exp holds digits 7..0 from left to right.
    task automatic frame_const(input string tag, input logic [7:0][7:0] exp);
        ticks(3);
        align_frame();
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (i % SCAN_DIV == 0) chk(tag, 32'(bus.seg), 32'(exp[i / SCAN_DIV]));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom();
        mem[3] = 32'hDEADBEEF;
        rst = 1'b1;
        bus.display_op = 3'd0;
        bus.ram_display_addr = 10'd0;
        bus.syscall_out = 32'd0;
        bus.pc = 32'd0;
        bus.cycle_cnt = 32'd0;
        bus.jump_cnt = 32'd0;
        bus.branch_cnt = 32'd0;
        bus.taken_cnt = 32'd0;

        ticks(3);
        rst = 1'b0;
        tick();
        chk("first_an", 32'(bus.an), 32'hFE);
        chk("first_seg", 32'(bus.seg), 32'hC0);
        ticks(40);

        bus.display_op = 3'd4;
        bus.pc = 32'h0040_1A3C;
        frame_const("pc_digit", {8'hFF, 8'hFF, 8'h99, 8'hC0, 8'hF9, 8'h88, 8'hB0, 8'hC6});

        bus.display_op = 3'd5;
        bus.ram_display_addr = 10'h003;
        tick();
        chk("ram_addr_reg", 32'(bus.ram_rd_addr), 32'h3);
        frame_const("ram_digit", {8'hA1, 8'h86, 8'h88, 8'hA1, 8'h83, 8'h86, 8'h86, 8'h8E});

        bus.display_op = 3'd0;
        bus.cycle_cnt = $urandom();
        ticks(3);
        align_frame();
        wait_digit(2);
        bus.display_op = 3'd1;
        bus.jump_cnt = $urandom();
        ticks(2 * FRAME);

        bus.display_op = 3'd7;
        ticks(2 * FRAME);

        bus.display_op = 3'd4;
        ticks(FRAME + 4);
        wait_digit(5);
        rst = 1'b1;
        tick();
        chk("rst_an", 32'(bus.an), 32'hFF);
        chk("rst_seg", 32'(bus.seg), 32'hFF);
        rst = 1'b0;
        tick();
        chk("restart_an", 32'(bus.an), 32'hFE);
        chk("restart_seg", 32'(bus.seg), 32'hC0);
        ticks(40);

        for (int it = 0; it < 60; it++) begin
            bus.display_op       = 3'($urandom_range(0, 7));
            bus.ram_display_addr = 10'($urandom_range(0, 15));
            bus.cycle_cnt        = $urandom() >> $urandom_range(0, 31);
            bus.jump_cnt         = $urandom() >> $urandom_range(0, 31);
            bus.branch_cnt       = $urandom() >> $urandom_range(0, 31);
            bus.taken_cnt        = $urandom() >> $urandom_range(0, 31);
            bus.pc               = $urandom() >> $urandom_range(0, 31);
            bus.syscall_out      = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                ticks($urandom_range(1, 2));
                rst = 1'b0;
            end
            ticks($urandom_range(1, 40));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
